score_display_scanner: RTL and testbench
========================================

# score_display_scanner

Upstream driver for the 4-digit seven-segment decoder in the Snake game display path. It captures a binary score, converts it to four BCD digits with a sequential shift-and-add-3 converter, and time-multiplexes the digits. Each cycle it presents a 2-bit digit select, a 4-bit digit value and an active-low dot bit, all registered, ready for the decoder's SEG_SELECT_IN, BIN_IN and DOT_IN inputs.

## Interface
- REFRESH_DIV, 100000: CLK cycles per digit slot (100 MHz gives 1 kHz per digit); legal range ≥ 2.
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SCORE_IN  input  14  binary score; values > 9999 saturate to 9999.
- SCORE_VALID  input  1  single-cycle load strobe for SCORE_IN.
- DOT_MASK  input  4  active-high dot enable per digit; bit i applies to digit i.
- SEG_SELECT_OUT  output  2  digit index 0..3, to the decoder's select input.
- BIN_OUT  output  4  BCD nibble of the selected digit; digit 0 is the least significant.
- DOT_OUT  output  1  active-low dot, equal to ~DOT_MASK[SEG_SELECT_OUT].
- BUSY  output  1  high while a conversion is in progress.

## Operation
- **Reset values.** RESET forces the following values in the same edge and takes priority over everything else. A reset during a conversion abandons it and also clears the pending flag.
  - Display register: 16'h0000.
  - Prescaler: 0. Digit index: 0.
  - SEG_SELECT_OUT: 0. BIN_OUT: 0. DOT_OUT: 1. BUSY: 0.
  - State: IDLE. Pending flag: clear.
- **Prescaler.** Counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and the digit index increments.
  - The index wraps 3→0.
  - Scanning never stalls, including during conversion.
- **Output register.** Every cycle it loads:
  - SEG_SELECT_OUT ← index.
  - BIN_OUT ← display[4·index+3 : 4·index].
  - DOT_OUT ← ~DOT_MASK[index].
- **State machine.** States IDLE, CONVERT, COMMIT.
  - **IDLE.**
    - If SCORE_VALID is high, the saturated SCORE_IN is captured into the binary shift register.
    - The BCD accumulator is cleared, the iteration count is set to 0, and the state moves to CONVERT.
  - **CONVERT.** One iteration per cycle, 14 iterations:
    - Each BCD nibble ≥ 5 has 3 added.
    - The 30-bit {bcd, bin} register is then shifted left by 1.
    - After iteration 13 the state moves to COMMIT.
  - **COMMIT.**
    - The display register ← BCD accumulator, all 16 bits in one edge, so no torn digits are ever shown.
    - Next state: IDLE. If the pending flag is set, it goes to CONVERT instead, loading the pending value and clearing the flag.
- **SCORE_VALID while BUSY** (CONVERT or COMMIT):
  - The value is stored in the pending register and the pending flag is set.
  - Later strobes overwrite it, so only the latest value is kept.
  - A strobe in the COMMIT cycle is pending, not lost.
- **Arithmetic.** Saturation compares SCORE_IN > 14'd9999 and substitutes 9999. The BCD result is therefore always 4 valid digits, 0..9 each.

## Timing
- **Conversion latency.** SCORE_VALID is sampled high in IDLE at cycle 0.
  - BUSY is high in cycles 1..15.
  - The display register is updated at the end of cycle 15.
  - BIN_OUT shows the new digit for the current index from cycle 17, so the total latency is 17 cycles.
- **Back-to-back updates.** With a pending value, the next CONVERT starts in cycle 16. BUSY stays high without a gap, and each further update takes another 15 cycles.
- **Scan rate.** The index changes once every REFRESH_DIV cycles, and SEG_SELECT_OUT follows one cycle later.
- **Output stability.** Outputs are glitch-free; all change only on CLK edges.

## Structure
- **Shared package `snake_display_pkg`:**
  - NUM_DIGITS = 4.
  - SCORE_MAX = 9999.
  - SCORE_W = 14.
  - State encoding constants for IDLE, CONVERT and COMMIT.
- **Sub-module `bin2bcd_seq`:**
  - Holds the CONVERT iteration logic.
  - Interface: start, 14-bit in, busy, done pulse, 16-bit BCD out.
  - The top level holds the prescaler, index, pending logic, display register and output register.

## Test plan
- **Reset:** hold RESET for 3 cycles mid-scan → all outputs at their reset values, index 0, BUSY 0.
- **Conversion:** REFRESH_DIV=4, SCORE_IN=1234 strobed → BUSY high for exactly 15 cycles; afterwards each full scan shows BIN_OUT 4,3,2,1 for SEG_SELECT_OUT 0,1,2,3.
- **Saturation:** SCORE_IN=14'h3FFF → digits 9,9,9,9; SCORE_IN=0 → 0,0,0,0.
- **Pending updates:** strobe 100, then strobe 5678 at cycle 5 and 42 at cycle 15 (the COMMIT cycle) → 100 is displayed, then 42; 5678 is never displayed; BUSY stays continuous until 42 is committed.
- **Dots:** DOT_MASK=4'b0101 → DOT_OUT is 0 at indices 0 and 2 and 1 at indices 1 and 3; the index wraps 3→0 every 4·REFRESH_DIV cycles.
- **Reset mid-conversion:** RESET at cycle 8 of converting 4321 → display stays 0000, BUSY 0, no later commit.

Source files
------------

// File: rtl/snake_display_pkg.sv
// rtl/snake_display_pkg.sv - shared constants, state encoding and score saturation for the score display path
package snake_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_MAX  = 9999;
  localparam int SCORE_W    = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CONV_ITERS = SCORE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  // Clamp a raw score so the BCD result always fits four decimal digits
  function automatic logic [SCORE_W-1:0] saturate_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
  endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// rtl/score_display_scanner_if.sv - score load and digit scan signals between game logic, scanner and decoder
interface score_display_scanner_if;
  import snake_display_pkg::*;

  logic [SCORE_W-1:0] SCORE_IN;
  logic               SCORE_VALID;
  logic [3:0]         DOT_MASK;
  logic [1:0]         SEG_SELECT_OUT;
  logic [3:0]         BIN_OUT;
  logic               DOT_OUT;
  logic               BUSY;

  modport master (
    output SCORE_IN, SCORE_VALID, DOT_MASK,
    input  SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BUSY
  );

  modport slave (
    input  SCORE_IN, SCORE_VALID, DOT_MASK,
    output SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BUSY
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
  import snake_display_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd_out
);

  localparam logic [3:0] LAST_ITER = 4'(CONV_ITERS - 1);

  logic [SCORE_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic [BCD_W-1:0]         adj;
  logic [BCD_W+SCORE_W-1:0] shifted;

  // Converter state registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Load on start, otherwise add 3 to every nibble >= 5 then shift {bcd, bin} left once
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done    = 1'b0;
    adj     = '0;
    shifted = '0;
    if (start) begin
      bin_d  = bin_in;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end
      shifted = {adj, bin_q} << 1;
      bcd_d   = shifted[BCD_W+SCORE_W-1 : SCORE_W];
      bin_d   = shifted[SCORE_W-1:0];
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - score capture, BCD conversion control and 4-digit time-multiplexed scan
module score_display_scanner
  import snake_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  score_display_scanner_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] pend_val_q, pend_val_d;
  logic               pend_flag_q, pend_flag_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         nib_q, nib_d;
  logic               dot_q, dot_d;
  logic               busy_q, busy_d;

  logic               conv_start;
  logic [SCORE_W-1:0] conv_val;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  bin2bcd_seq u_bin2bcd (
    .clk     (CLK),
    .rst     (RESET),
    .start   (conv_start),
    .bin_in  (conv_val),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // All control, display and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      disp_q      <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      nib_q       <= '0;
      dot_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_val_q  <= pend_val_d;
      pend_flag_q <= pend_flag_d;
      disp_q      <= disp_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      nib_q       <= nib_d;
      dot_q       <= dot_d;
      busy_q      <= busy_d;
    end
  end

  // Free-running scan: prescaler advances the digit index, outputs register the current digit
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    sel_d = idx_q;
    nib_d = disp_q[{idx_q, 2'b00} +: 4];
    dot_d = ~bus.DOT_MASK[idx_q];
  end

  // Conversion FSM with a single-entry latest-wins pending slot for strobes arriving while busy
  always_comb begin
    state_d     = state_q;
    pend_val_d  = pend_val_q;
    pend_flag_d = pend_flag_q;
    disp_d      = disp_q;
    conv_start  = 1'b0;
    conv_val    = '0;
    if ((state_q != ST_IDLE) && bus.SCORE_VALID) begin
      pend_val_d  = bus.SCORE_IN;
      pend_flag_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.SCORE_VALID) begin
          conv_start = 1'b1;
          conv_val   = saturate_score(bus.SCORE_IN);
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // An idle converter without done cannot occur; the guard only prevents a stuck FSM
        if (conv_done || !conv_busy) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d  = conv_bcd;
        state_d = ST_IDLE;
        // A strobe in this very cycle is already folded into pend_*_d, so it wins over older values
        if (pend_flag_d) begin
          conv_start  = 1'b1;
          conv_val    = saturate_score(pend_val_d);
          pend_flag_d = 1'b0;
          state_d     = ST_CONVERT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.SEG_SELECT_OUT = sel_q;
  assign bus.BIN_OUT        = nib_q;
  assign bus.DOT_OUT        = dot_q;
  assign bus.BUSY           = busy_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// tb/tb_score_display_scanner.sv - randomized and directed bench for score_display_scanner against a decimal reference model
module tb_score_display_scanner;

  localparam int DIV = 4;
  localparam int CONV_CYCLES = 15;

  logic clk;
  logic rst;

  score_display_scanner_if bus ();

  score_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int p10 [4] = '{1, 10, 100, 1000};
  int lut1234 [4] = '{4, 3, 2, 1};

  // Reference model: decimal display value, conversion countdown, pending slot, scan position
  int m_disp, m_cur, m_rem, m_pend, m_pendv, m_presc, m_idx;
  int m_sel, m_bin, m_dot, m_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_disp = 0; m_cur = 0; m_rem = 0; m_pend = 0; m_pendv = 0;
      m_presc = 0; m_idx = 0;
      m_sel = 0; m_bin = 0; m_dot = 1; m_busy = 0;
    end else begin
      m_sel = m_idx;
      m_bin = (m_disp / p10[m_idx]) % 10;
      m_dot = bus.DOT_MASK[m_idx] ? 0 : 1;
      m_presc++;
      if (m_presc == DIV) begin
        m_presc = 0;
        m_idx = (m_idx + 1) % 4;
      end
      if (m_rem == 0) begin
        if (bus.SCORE_VALID) begin
          m_cur = sat(int'(bus.SCORE_IN));
          m_rem = CONV_CYCLES;
        end
      end else begin
        if (bus.SCORE_VALID) begin
          m_pend = 1;
          m_pendv = int'(bus.SCORE_IN);
        end
        if (m_rem == 1) begin
          m_disp = m_cur;
          m_rem = 0;
          if (m_pend != 0) begin
            m_cur = sat(m_pendv);
            m_pend = 0;
            m_rem = CONV_CYCLES;
          end
        end else begin
          m_rem--;
        end
      end
      m_busy = (m_rem > 0) ? 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel",  int'(bus.SEG_SELECT_OUT), m_sel);
    chk("bin",  int'(bus.BIN_OUT),        m_bin);
    chk("dot",  int'(bus.DOT_OUT),        m_dot);
    chk("busy", int'(bus.BUSY),           m_busy);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sel"},  int'(bus.SEG_SELECT_OUT), 0);
    chk({tag, "_bin"},  int'(bus.BIN_OUT),        0);
    chk({tag, "_dot"},  int'(bus.DOT_OUT),        1);
    chk({tag, "_busy"}, int'(bus.BUSY),           0);
  endtask

  initial begin
    int bc;
    int seen_big;
    int wraps;
    int prev_sel;

    rst = 1'b1;
    bus.SCORE_IN = '0;
    bus.SCORE_VALID = 1'b0;
    bus.DOT_MASK = 4'b0000;
    repeat (3) step();
    check_reset_values("rst_init");
    rst = 1'b0;

    // Conversion of 1234: BUSY length and digit order across a full scan
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      bus.SCORE_VALID = (c == 0);
      bus.SCORE_IN = 14'd1234;
      step();
      if (bus.BUSY) bc++;
    end
    bus.SCORE_VALID = 1'b0;
    chk("busy_len_1234", bc, CONV_CYCLES);
    for (int c = 0; c < 4 * DIV; c++) begin
      step();
      chk("digit_1234", int'(bus.BIN_OUT), lut1234[bus.SEG_SELECT_OUT]);
    end

    // Reset held 3 cycles mid-scan
    repeat (5) step();
    rst = 1'b1;
    repeat (3) step();
    check_reset_values("rst_mid");
    rst = 1'b0;

    // Saturation high and zero
    bus.SCORE_IN = 14'h3FFF;
    bus.SCORE_VALID = 1'b1;
    step();
    bus.SCORE_VALID = 1'b0;
    repeat (20) step();
    for (int c = 0; c < 4 * DIV; c++) begin
      step();
      chk("digit_sat", int'(bus.BIN_OUT), 9);
    end
    bus.SCORE_IN = 14'd0;
    bus.SCORE_VALID = 1'b1;
    step();
    bus.SCORE_VALID = 1'b0;
    repeat (20) step();
    for (int c = 0; c < 4 * DIV; c++) begin
      step();
      chk("digit_zero", int'(bus.BIN_OUT), 0);
    end

    // Pending: 100 at c0, 5678 at c5, 42 in the COMMIT cycle c15
    bc = 0;
    seen_big = 0;
    for (int c = 0; c < 60; c++) begin
      bus.SCORE_VALID = (c == 0 || c == 5 || c == 15);
      bus.SCORE_IN = (c == 0) ? 14'd100 : (c == 5) ? 14'd5678 : 14'd42;
      step();
      if (c <= 40 && bus.BUSY) bc++;
      if (bus.BIN_OUT >= 4'd5) seen_big = 1;
    end
    bus.SCORE_VALID = 1'b0;
    chk("busy_len_pending", bc, 2 * CONV_CYCLES);
    chk("no_5678_shown", seen_big, 0);
    for (int c = 0; c < 4 * DIV; c++) begin
      step();
      chk("digit_42", int'(bus.BIN_OUT), (bus.SEG_SELECT_OUT == 2'd0) ? 2 :
                                         (bus.SEG_SELECT_OUT == 2'd1) ? 4 : 0);
    end

    // Dots with mask 0101 and index wrap every 4*DIV cycles
    bus.DOT_MASK = 4'b0101;
    step();
    prev_sel = int'(bus.SEG_SELECT_OUT);
    wraps = 0;
    for (int c = 0; c < 8 * DIV; c++) begin
      step();
      chk("dot_0101", int'(bus.DOT_OUT),
          (bus.SEG_SELECT_OUT == 2'd0 || bus.SEG_SELECT_OUT == 2'd2) ? 0 : 1);
      if (prev_sel == 3 && bus.SEG_SELECT_OUT == 2'd0) wraps++;
      prev_sel = int'(bus.SEG_SELECT_OUT);
    end
    chk("wrap_count", wraps, 2);

    // Reset at cycle 8 of converting 4321 abandons it
    bc = 0;
    seen_big = 0;
    for (int c = 0; c < 40; c++) begin
      bus.SCORE_VALID = (c == 0);
      bus.SCORE_IN = 14'd4321;
      rst = (c == 8);
      step();
      if (c >= 8) begin
        if (bus.BUSY) bc++;
        if (bus.BIN_OUT != 4'd0) seen_big = 1;
      end
    end
    bus.SCORE_VALID = 1'b0;
    rst = 1'b0;
    chk("busy_after_rst", bc, 0);
    chk("disp_after_rst", seen_big, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.SCORE_VALID = ($urandom_range(0, 9) == 0);
      bus.SCORE_IN = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 49) == 0) bus.DOT_MASK = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
